multicycle_control: RTL and testbench



---
 rtl/multicycle_control_if.sv | 52 +++++
 rtl/multicycle_control.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
//   Bundle of the controller's datapath-facing signals.
//   Inputs to the controller:
//     op[5:0]        opcode field from the instruction register
//     zero           ALU zero flag (only meaningful in BEQEX)
//     mem_ready      memory has finished the current read/write this cycle
//   Outputs from the controller:
//     pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//     reg_write, reg_dst, mem_to_reg, alu_src_a    single-bit strobes/selects
//     alu_src_b[1:0], alu_op[1:0], pc_source[1:0] 3:1 mux selects
//     instr_done     one-cycle pulse on an instruction's final cycle
//     illegal_op     one-cycle pulse when DECODE sees an unknown opcode
//   Modports:
//     master - the controller (drives the control lines)
//     slave  - the datapath side (drives opcode, zero and mem_ready)
// ---------------------------------------------------------------------------
interface multicycle_control_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Sequencing FSM for the 8-bit multicycle MIPS datapath. Steps each
//   instruction through fetch / decode / execute / memory / writeback and
//   drives the datapath enables and 3:1 mux selects in every cycle.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high; forces IDLE from any state
//     bus    multicycle_control_if.master (opcode, zero, mem_ready in;
//            all control strobes, selects and status pulses out)
//   Outputs are combinational decodes of the state register; only FETCH,
//   MEMRD and MEMWR look at mem_ready. The controller never looks at zero:
//   the datapath takes the branch on pc_write_cond & zero.
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEX   = 4'd7,
    S_RTWB   = 4'd8,
    S_BEQEX  = 4'd9,
    S_JEX    = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // True for the six opcodes this controller knows how to sequence.
  function automatic logic is_known_op(input logic [5:0] op);
    logic known;
    case (op)
      OP_RTYPE, OP_LB, OP_SB, OP_BEQ, OP_J, OP_ADDI: known = 1'b1;
      default:                                       known = 1'b0;
    endcase
    return known;
  endfunction

  // State register with synchronous reset to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and per-state control decode.
  always_comb begin
    w_next_state      = r_state;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REGB;
    bus.alu_op        = ALUOP_ADD;
    bus.pc_source     = PCSRC_ALU;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
      end

      // PC+1 is computed every fetch cycle but only committed, together
      // with the IR load, on the cycle memory delivers the word.
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_ONE;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          w_next_state = S_DECODE;
        end else begin
          w_next_state = S_FETCH;
        end
      end

      // ALU speculatively computes PC + imm as the branch target.
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LB, OP_SB: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_RTEX;
          OP_BEQ:       w_next_state = S_BEQEX;
          OP_J:         w_next_state = S_JEX;
          OP_ADDI:      w_next_state = S_ADDIEX;
          default:      w_next_state = S_FETCH;
        endcase
        if (!is_known_op(bus.op)) begin
          bus.illegal_op = 1'b1;
          bus.instr_done = 1'b1;
        end else begin
          bus.illegal_op = 1'b0;
          bus.instr_done = 1'b0;
        end
      end

      // Only LB/SB reach here; the IR is stable until the next fetch.
      // Anything else is retired immediately so the done pulse is not lost.
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        if (bus.op == OP_LB) begin
          w_next_state = S_MEMRD;
        end else if (bus.op == OP_SB) begin
          w_next_state = S_MEMWR;
        end else begin
          w_next_state   = S_FETCH;
          bus.instr_done = 1'b1;
        end
      end

      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          w_next_state = S_MEMWB;
        end else begin
          w_next_state = S_MEMRD;
        end
      end

      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        w_next_state   = S_FETCH;
      end

      // A store ends on the cycle memory accepts it.
      S_MEMWR: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
        if (bus.mem_ready) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_MEMWR;
        end
      end

      S_RTEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_REGB;
        bus.alu_op    = ALUOP_FUNCT;
        w_next_state  = S_RTWB;
      end

      S_RTWB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
        w_next_state   = S_FETCH;
      end

      // pc_write_cond is deliberately ungated; the datapath ANDs it with zero.
      S_BEQEX: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_src_b     = SRCB_REGB;
        bus.alu_op        = ALUOP_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
        bus.instr_done    = 1'b1;
        w_next_state      = S_FETCH;
      end

      S_JEX: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = PCSRC_JUMP;
        bus.instr_done = 1'b1;
        w_next_state   = S_FETCH;
      end

      S_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        w_next_state  = S_ADDIWB;
      end

      S_ADDIWB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        w_next_state   = S_FETCH;
      end

      // Unreachable encodings recover through IDLE with all outputs low.
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Directed sequences for each instruction class, reset in the middle of
//   memory waits, then a long random opcode / mem_ready stream.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  multicycle_control_if bus_if ();

  multicycle_control u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q [$];
  string       tag_q [$];
  bit          done_q[$];

  // Field order: pcw pcwc iord mr mw irw rw rd m2r asa asb aop psrc done ill
  function automatic logic [17:0] pk(
    input logic pcw, input logic pcwc, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic rw, input logic rd,
    input logic m2r, input logic asa, input logic [1:0] asb,
    input logic [1:0] aop, input logic [1:0] psrc, input logic done,
    input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, rw, rd, m2r, asa, asb, aop, psrc, done, ill};
  endfunction

  function automatic logic [17:0] observed();
    return {bus_if.pc_write, bus_if.pc_write_cond, bus_if.i_or_d,
            bus_if.mem_read, bus_if.mem_write, bus_if.ir_write,
            bus_if.reg_write, bus_if.reg_dst, bus_if.mem_to_reg,
            bus_if.alu_src_a, bus_if.alu_src_b, bus_if.alu_op,
            bus_if.pc_source, bus_if.instr_done, bus_if.illegal_op};
  endfunction

  // Expected output vectors for each state.
  function automatic logic [17:0] e_idle();
    return 18'd0;
  endfunction
  function automatic logic [17:0] e_fetch(input logic r);
    return pk(r,1'b0,1'b0,1'b1,1'b0,r,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0);
  endfunction
  function automatic logic [17:0] e_decode(input logic bad);
    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,bad,bad);
  endfunction
  function automatic logic [17:0] e_memadr();
    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
  endfunction
  function automatic logic [17:0] e_memrd();
    return pk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0);
  endfunction
  function automatic logic [17:0] e_memwb();
    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0);
  endfunction
  function automatic logic [17:0] e_memwr(input logic r);
    return pk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,r,1'b0);
  endfunction
  function automatic logic [17:0] e_rtex();
    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0);
  endfunction
  function automatic logic [17:0] e_rtwb();
    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0);
  endfunction
  function automatic logic [17:0] e_beqex();
    return pk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0);
  endfunction
  function automatic logic [17:0] e_jex();
    return pk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0);
  endfunction
  function automatic logic [17:0] e_addiex();
    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0);
  endfunction
  function automatic logic [17:0] e_addiwb();
    return pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0);
  endfunction

  function automatic logic known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LB) || (op == OP_SB) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive mem_ready, queue the expectation, compare at the
  // falling edge, then step past the next rising edge.
  task automatic cyc(input string tag, input logic mr, input logic [17:0] e);
    logic [17:0] ev;
    string       tv;
    bus_if.mem_ready = mr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    ev = exp_q.pop_front();
    tv = tag_q.pop_front();
    check(tv, {14'd0, observed()}, {14'd0, ev});
    @(posedge clk);
    #1;
  endtask

  logic [5:0] rop;
  logic       is_dec;
  logic       is_fetch;
  logic       ld;

  initial begin
    reset            = 1'b1;
    bus_if.op        = OP_RTYPE;
    bus_if.zero      = 1'b0;
    bus_if.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // R-type: done in the 5th cycle after reset release
    cyc("rt_idle",   1'b1, e_idle());
    cyc("rt_fetch",  1'b1, e_fetch(1'b1));
    cyc("rt_decode", 1'b1, e_decode(1'b0));
    cyc("rt_ex",     1'b1, e_rtex());
    cyc("rt_wb",     1'b1, e_rtwb());

    // LB with three wait cycles in MEMRD (8 cycles total)
    bus_if.op = OP_LB;
    cyc("lb_fetch",  1'b1, e_fetch(1'b1));
    cyc("lb_decode", 1'b0, e_decode(1'b0));
    cyc("lb_adr",    1'b0, e_memadr());
    cyc("lb_rd_w0",  1'b0, e_memrd());
    cyc("lb_rd_w1",  1'b0, e_memrd());
    cyc("lb_rd_w2",  1'b0, e_memrd());
    cyc("lb_rd",     1'b1, e_memrd());
    cyc("lb_wb",     1'b0, e_memwb());

    // SB with one wait in FETCH and one in MEMWR
    bus_if.op = OP_SB;
    cyc("sb_fetch_w", 1'b0, e_fetch(1'b0));
    cyc("sb_fetch",   1'b1, e_fetch(1'b1));
    cyc("sb_decode",  1'b1, e_decode(1'b0));
    cyc("sb_adr",     1'b1, e_memadr());
    cyc("sb_wr_w",    1'b0, e_memwr(1'b0));
    cyc("sb_wr",      1'b1, e_memwr(1'b1));

    // BEQ: controller output independent of zero
    bus_if.op   = OP_BEQ;
    bus_if.zero = 1'b1;
    cyc("beq_fetch",  1'b1, e_fetch(1'b1));
    cyc("beq_decode", 1'b1, e_decode(1'b0));
    bus_if.zero = 1'b0;
    cyc("beq_ex",     1'b0, e_beqex());

    // J
    bus_if.op = OP_J;
    cyc("j_fetch",  1'b1, e_fetch(1'b1));
    cyc("j_decode", 1'b1, e_decode(1'b0));
    cyc("j_ex",     1'b1, e_jex());

    // ADDI
    bus_if.op = OP_ADDI;
    cyc("addi_fetch",  1'b1, e_fetch(1'b1));
    cyc("addi_decode", 1'b1, e_decode(1'b0));
    cyc("addi_ex",     1'b1, e_addiex());
    cyc("addi_wb",     1'b1, e_addiwb());

    // Illegal opcode: done in DECODE, straight back to FETCH
    bus_if.op = OP_BAD;
    cyc("bad_fetch",  1'b1, e_fetch(1'b1));
    cyc("bad_decode", 1'b1, e_decode(1'b1));
    cyc("bad_refetch", 1'b0, e_fetch(1'b0));

    // Reset while waiting in FETCH
    reset = 1'b1;
    cyc("rst_fetch_w", 1'b0, e_fetch(1'b0));
    reset = 1'b0;
    cyc("rst_fetch_idle", 1'b0, e_idle());

    // Reset while a store is waiting in MEMWR
    bus_if.op = OP_SB;
    cyc("rsw_fetch",  1'b1, e_fetch(1'b1));
    cyc("rsw_decode", 1'b1, e_decode(1'b0));
    cyc("rsw_adr",    1'b1, e_memadr());
    cyc("rsw_wr_w",   1'b0, e_memwr(1'b0));
    reset = 1'b1;
    cyc("rsw_wr_rst", 1'b0, e_memwr(1'b0));
    reset = 1'b0;
    cyc("rsw_idle",   1'b0, e_idle());
    cyc("rsw_fetch2", 1'b1, e_fetch(1'b1));

    // Random stream; op only changes when the IR loads
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    done_q.delete();
    for (int i = 0; i < 10000; i++) begin
      bus_if.mem_ready = 1'($urandom_range(0, 1));
      bus_if.zero      = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rnd_srcb_not_11", {31'd0, bus_if.alu_src_b == 2'b11}, 32'd0);
      check("rnd_pcsrc_not_11", {31'd0, bus_if.pc_source == 2'b11}, 32'd0);
      check("rnd_rd_wr_excl", {31'd0, bus_if.mem_read & bus_if.mem_write}, 32'd0);
      is_dec   = !bus_if.alu_src_a && (bus_if.alu_src_b == 2'b10);
      is_fetch = bus_if.mem_read && !bus_if.i_or_d;
      if (is_fetch) begin
        check("rnd_no_done_in_fetch", {31'd0, bus_if.instr_done}, 32'd0);
      end
      if (is_dec) begin
        check("rnd_decode_prev_done", done_q.size(), 32'd0);
        check("rnd_illegal_flag", {31'd0, bus_if.illegal_op}, {31'd0, !known_op(bus_if.op)});
        done_q.push_back(1'b1);
      end else begin
        check("rnd_illegal_outside_dec", {31'd0, bus_if.illegal_op}, 32'd0);
      end
      if (bus_if.instr_done) begin
        check("rnd_done_has_decode", done_q.size(), 32'd1);
        if (done_q.size() > 0) begin
          void'(done_q.pop_front());
        end
      end
      ld = bus_if.ir_write;
      @(posedge clk);
      #1;
      if (ld) begin
        case ($urandom_range(0, 6))
          0:       rop = OP_RTYPE;
          1:       rop = OP_LB;
          2:       rop = OP_SB;
          3:       rop = OP_BEQ;
          4:       rop = OP_J;
          5:       rop = OP_ADDI;
          default: rop = 6'($urandom_range(0, 63));
        endcase
        bus_if.op = rop;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
